// File: rtl/fadd_issue_arbiter.sv
// fadd_issue_arbiter: round-robin issue of NREQ requesters into a shared LAT-stage fadder.
// Define FADD_ARB_PERF_EN to add saturating perf_issue/perf_stall counters.
module fadd_issue_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT = 2,
  localparam int IDW = $clog2(NREQ),
  localparam int CW = $clog2(LAT+1)
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               flush,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  input  logic [NREQ*2-1:0]  req_rm,
  output logic [31:0]        fa_a,
  output logic [31:0]        fa_b,
  output logic               fa_sub,
  output logic [1:0]         fa_rm,
  output logic               fa_e,
  input  logic [31:0]        fa_s,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_s,
  output logic [CW-1:0]      inflight
`ifdef FADD_ARB_PERF_EN
  ,
  output logic [31:0]        perf_issue,
  output logic [31:0]        perf_stall
`endif
);
  logic [LAT-1:0] r_v;
  logic [IDW-1:0] r_id [LAT];
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_gnt;
  logic           w_any;
  logic           w_issue;
  // Scan downward so the requester closest to r_ptr is written last and wins.
  always_comb begin
    w_gnt = r_ptr;
    w_any = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr)+k) % NREQ]) begin
        w_gnt = IDW'((int'(r_ptr)+k) % NREQ);
        w_any = 1'b1;
      end
    end
  end
  assign fa_e      = ~r_v[LAT-1] | rsp_ready;
  assign w_issue   = w_any & fa_e & ~flush & clrn;
  assign req_ready = w_issue ? NREQ'(1) << w_gnt : '0;
  assign fa_a      = req_a[w_gnt*32 +: 32];
  assign fa_b      = req_b[w_gnt*32 +: 32];
  assign fa_sub    = req_sub[w_gnt];
  assign fa_rm     = req_rm[w_gnt*2 +: 2];
  assign rsp_valid = r_v[LAT-1];
  assign rsp_id    = r_id[LAT-1];
  assign rsp_s     = fa_s;
  assign inflight  = CW'($countones(r_v));
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_v   <= '0;
      r_id  <= '{default: '0};
      r_ptr <= '0;
    end else begin
      if (flush) r_v <= '0;
      else if (fa_e) begin
        r_v   <= {r_v[LAT-2:0], w_issue};
        r_id[0] <= w_gnt;
        for (int k = 1; k < LAT; k++) r_id[k] <= r_id[k-1];
      end
      if (w_issue) r_ptr <= (int'(w_gnt) == NREQ-1) ? '0 : w_gnt + 1'b1;
    end
  end
`ifdef FADD_ARB_PERF_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (w_issue && ~&perf_issue) perf_issue <= perf_issue + 1'b1;
      if (|req_valid && !fa_e && ~&perf_stall) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule
